// File: rtl/fib_pkg.sv
// Shared types and seed constants for the Fibonacci/Lucas stream generator.
package fib_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fib_state_t;

    // Classic Fibonacci sequence: 1, 1, 2, 3, 5, ...
    localparam int FIB_SEED0   = 1;
    localparam int FIB_SEED1   = 1;

    // Lucas sequence: 2, 1, 3, 4, 7, ...
    localparam int LUCAS_SEED0 = 2;
    localparam int LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_step.sv
// One recurrence step: W-bit wrapped sum of two terms plus the carry out,
// which flags that the true sum no longer fits in W bits.
module fib_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full_sum;

    // Widen by one bit so the carry is visible.
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b};
        sum      = full_sum[W-1:0];
        carry    = full_sum[W];
    end

endmodule

// File: rtl/fib_stream_gen.sv
// Streams n terms of t(k) = t(k-1) + t(k-2) mod 2^W from run-time seeds over
// a valid/ready interface, with start/busy/done handshaking and sticky
// overflow detection (optionally stopping before the first wrapped term).
module fib_stream_gen
    import fib_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  seed0,
    input  logic [W-1:0]  seed1,
    input  logic [CW-1:0] n,
    input  logic          stop_on_ovf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_index,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    fib_state_t    state, state_next;

    // a is the term on the output, b the one after it; the flags mark
    // terms whose true value no longer fits in W bits.
    logic [W-1:0]  a, b;
    logic          a_ovf, b_ovf;
    logic [CW-1:0] cnt_n;
    logic          stop_mode;

    logic [W-1:0]  sum;
    logic          carry;
    logic          handshake;
    logic          stop_hit;
    logic          last;

    fib_step #(.W(W)) u_step (
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign out_data  = a;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update together from the values present before the edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and end-of-run detection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        handshake  = 1'b0;
        stop_hit   = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (n != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                handshake = out_ready;
                // In stop mode the term after the current one has wrapped,
                // so the current term is the final one presented.
                stop_hit  = stop_mode && b_ovf;
                last      = (out_index == cnt_n - CW'(1)) || stop_hit;
                if (handshake && last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Term registers, flags, index, done pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            a_ovf     <= 1'b0;
            b_ovf     <= 1'b0;
            cnt_n     <= '0;
            stop_mode <= 1'b0;
            out_index <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        overflow <= 1'b0;
                        if (n != '0) begin
                            a         <= seed0;
                            b         <= seed1;
                            a_ovf     <= 1'b0;
                            b_ovf     <= 1'b0;
                            cnt_n     <= n;
                            stop_mode <= stop_on_ovf;
                            out_index <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (a_ovf) begin
                            overflow <= 1'b1;
                        end
                        if (last) begin
                            done <= 1'b1;
                            if (stop_hit) begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            a         <= b;
                            b         <= sum;
                            a_ovf     <= b_ovf;
                            b_ovf     <= carry | a_ovf | b_ovf;
                            out_index <= out_index + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_stream_gen.sv
// Self-checking bench for fib_stream_gen (W=8 so wrap-around is reachable).
// Expected terms come from exact 64-bit integer arithmetic on the seeds.
module tb_fib_stream_gen;

    localparam int W  = 8;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  seed0, seed1;
    logic [CW-1:0] n;
    logic          stop_on_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_index;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Expected run outcome, filled by build_model.
    logic [W-1:0] exp_data[$];
    bit           exp_wrap[$];
    int           exp_cnt;
    bit           exp_ovf;

    always #5 clk = ~clk;

    fib_stream_gen #(.W(W), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed0       (seed0),
        .seed1       (seed1),
        .n           (n),
        .stop_on_ovf (stop_on_ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    // Exact (unwrapped) sequence; a term is "wrapped" when its true value
    // needs more than W bits.
    task automatic build_model(input int s0, input int s1, input int nn, input bit stop);
        longint unsigned tv[0:64];
        longint unsigned limit;
        int first_wrap;
        limit = 64'd1 << W;
        tv[0] = longint'(s0);
        tv[1] = longint'(s1);
        for (int k = 2; k <= nn; k++) tv[k] = tv[k-1] + tv[k-2];
        first_wrap = 1000;
        for (int k = 0; k <= nn; k++)
            if (tv[k] >= limit && first_wrap == 1000) first_wrap = k;
        if (stop) begin
            exp_cnt = (first_wrap < nn) ? first_wrap : nn;
            exp_ovf = (first_wrap <= nn);
        end else begin
            exp_cnt = nn;
            exp_ovf = (first_wrap <= nn - 1);
        end
        exp_data.delete();
        exp_wrap.delete();
        for (int k = 0; k < exp_cnt; k++) begin
            exp_data.push_back(W'(tv[k] % limit));
            exp_wrap.push_back(tv[k] >= limit);
        end
    endtask

    // Called at a negedge: presents a start for one cycle.
    task automatic issue_start(input int s0, input int s1, input int nn, input bit stop,
                               input string name);
        build_model(s0, s1, nn, stop);
        seed0       = W'(s0);
        seed1       = W'(s1);
        n           = CW'(nn);
        stop_on_ovf = stop;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s start_clears_ovf got %b exp 0", name, overflow);
        end
        if (nn != 0) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s latency1 valid %b busy %b exp 1 1", name, out_valid, busy);
            end
        end
    endtask

    // Consumes the stream until done; returns at the negedge where done is seen.
    // mode 0: ready always, 1: ready toggles 1010.., 2: random ready.
    task automatic collect(input int mode, input bit poke, input string name);
        int           got;
        int           cyc;
        bit           fin;
        bit           seen_ovf;
        bit           held;
        logic [W-1:0] hd;
        logic [CW-1:0] hi;
        got = 0; cyc = 0; fin = 0; seen_ovf = 0; held = 0; hd = '0; hi = '0;
        while (!fin && cyc < 400) begin
            start = 1'b0;
            if (done === 1'b1) begin
                fin = 1;
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s end_idle valid %b busy %b exp 0 0", name, out_valid, busy);
                end
                checks++;
                if (got != exp_cnt) begin
                    errors++;
                    $display("FAIL %s term_count got %0d exp %0d", name, got, exp_cnt);
                end
                checks++;
                if (overflow !== exp_ovf) begin
                    errors++;
                    $display("FAIL %s final_ovf got %b exp %b", name, overflow, exp_ovf);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s valid_dropped got %b exp 1 after %0d terms", name, out_valid, got);
                    fin = 1;
                end else begin
                    if (held) begin
                        checks++;
                        if (out_data !== hd || out_index !== hi) begin
                            errors++;
                            $display("FAIL %s hold data %0d idx %0d exp %0d %0d",
                                     name, out_data, out_index, hd, hi);
                        end
                    end
                    checks++;
                    if (overflow !== seen_ovf) begin
                        errors++;
                        $display("FAIL %s mid_ovf got %b exp %b after %0d terms",
                                 name, overflow, seen_ovf, got);
                    end
                    case (mode)
                        0:       out_ready = 1'b1;
                        1:       out_ready = (cyc % 2 == 0);
                        default: out_ready = 1'($urandom_range(0, 1));
                    endcase
                    if (poke && cyc == 1) begin
                        start = 1'b1;
                        seed0 = W'($urandom);
                        seed1 = W'($urandom);
                    end
                    if (out_ready) begin
                        held = 0;
                        if (got < exp_cnt) begin
                            checks++;
                            if (out_data !== exp_data[got] || out_index !== CW'(got)) begin
                                errors++;
                                $display("FAIL %s term data %0d idx %0d exp %0d %0d",
                                         name, out_data, out_index, exp_data[got], got);
                            end
                            seen_ovf = seen_ovf | exp_wrap[got];
                        end else begin
                            errors++;
                            checks++;
                            $display("FAIL %s extra_term data %0d idx %0d exp none", name, out_data, out_index);
                        end
                        got++;
                    end else begin
                        held = 1;
                        hd   = out_data;
                        hi   = out_index;
                    end
                    @(negedge clk);
                end
            end
            cyc++;
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got no done exp done within 400 cycles", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        seed0 = '0; seed1 = '0; n = '0; stop_on_ovf = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset v%b d%0d i%0d b%b dn%b o%b exp all 0",
                     out_valid, out_data, out_index, busy, done, overflow);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fibonacci;
        issue_start(1, 1, 5, 0, "fib");
        collect(0, 0, "fib");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL fib done_one_cycle got %b exp 0", done);
        end
    endtask

    task automatic test_lucas_backpressure;
        issue_start(2, 1, 6, 0, "lucas");
        collect(1, 0, "lucas");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL lucas done_one_cycle got %b exp 0", done);
        end
    endtask

    task automatic test_wrap;
        issue_start(1, 1, 14, 0, "wrap");
        collect(0, 0, "wrap");
        repeat (3) @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap ovf_sticky got %b exp 1", overflow);
        end
    endtask

    task automatic test_zero_n;
        issue_start(5, 7, 0, 0, "zero_n");
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_n done %b valid %b exp 1 0", done, out_valid);
        end
        collect(0, 0, "zero_n");
        @(negedge clk);
    endtask

    task automatic test_stop;
        issue_start(1, 1, 14, 1, "stop");
        collect(2, 0, "stop");
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        issue_start(3, 4, 8, 0, "busy_start");
        collect(1, 1, "busy_start");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        issue_start(1, 2, 10, 0, "mid_rst");
        out_ready = 1'b1;
        cyc = 0;
        while (out_index !== CW'(3) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (out_index !== CW'(3)) begin
            errors++;
            $display("FAIL mid_rst reach_idx3 got %0d exp 3", out_index);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst abort valid %b busy %b done %b exp 0 0 0", out_valid, busy, done);
        end
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        issue_start(1, 1, 6, 0, "after_rst");
        collect(2, 0, "after_rst");
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        issue_start(1, 1, 3, 0, "b2b_first");
        collect(0, 0, "b2b_first");
        issue_start(2, 1, 4, 0, "b2b_second");
        collect(1, 0, "b2b_second");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b done_one_cycle got %b exp 0", done);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 12; r++) begin
            int s0, s1, nn, md;
            bit st;
            s0 = int'($urandom_range(0, 255));
            s1 = int'($urandom_range(0, 255));
            nn = (r % 4 == 3) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 20));
            st = 1'($urandom_range(0, 1));
            md = int'($urandom_range(0, 2));
            issue_start(s0, s1, nn, st, "random");
            collect(md, 0, "random");
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_fibonacci();
        test_lucas_backpressure();
        test_wrap();
        test_zero_n();
        test_stop();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
